dwconv_tile_scheduler: RTL and testbench

Sequencer for the 3x3 depthwise convolution engine. Walks every output pixel of a channel tile (channel outer, row, column inner) and requests each 3x3 window from the window-fetch unit. For each pixel it pulses the engine's clear and start, captures the result, and streams it downstream with coordinates. Sits between the layer controller (config/start) and the engine, window fetcher and requantiser.

---
 rtl/dwconv_tile_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_dwconv_tile_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dwconv_tile_scheduler.sv
// Tile sequencer for the 3x3 depthwise convolution engine: walks every output pixel
// (channel, row, column), fetches its window, fires the engine and streams the result out.
module dwconv_tile_scheduler #(
  parameter int DIM_W   = 8,
  parameter int CH_W    = 10,
  parameter int TIMEOUT = 64
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [DIM_W-1:0]    i_cfg_height,
  input  logic [DIM_W-1:0]    i_cfg_width,
  input  logic [CH_W-1:0]     i_cfg_channels,
  input  logic [1:0]          i_cfg_stride,
  input  logic                i_cfg_pad,
  input  logic                i_start,
  input  logic                i_abort,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic                o_win_req,
  input  logic                i_win_ack,
  output logic [DIM_W:0]      o_win_row,
  output logic [DIM_W:0]      o_win_col,
  output logic [CH_W-1:0]     o_win_chan,
  output logic                o_conv_clear,
  output logic                o_conv_start,
  input  logic [31:0]         i_conv_result,
  input  logic                i_conv_result_valid,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [31:0]         o_out_data,
  output logic [DIM_W-1:0]    o_out_row,
  output logic [DIM_W-1:0]    o_out_col,
  output logic [CH_W-1:0]     o_out_chan,
  output logic                o_out_last,
  output logic [2:0]          o_dbg_state
);

  // Handshakes: win_req holds until win_ack is sampled high; out_valid holds data and
  // coordinates stable until a cycle where out_valid && out_ready, which is the transfer.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_FIRE  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_EMIT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [DIM_W:0] K_ONE   = (DIM_W+1)'(1);
  localparam logic [DIM_W:0] K_THREE = (DIM_W+1)'(3);
  localparam logic [CH_W-1:0] CH_ONE = CH_W'(1);
  localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);
  localparam logic [WD_W-1:0] WD_END = WD_W'(TIMEOUT - 1);

  logic [2:0]       r_state;
  logic [DIM_W:0]   r_oh;
  logic [DIM_W:0]   r_ow;
  logic [CH_W-1:0]  r_chans;
  logic             r_stride2;
  logic             r_pad;
  logic [DIM_W-1:0] r_oy;
  logic [DIM_W-1:0] r_ox;
  logic [CH_W-1:0]  r_c;
  logic [WD_W-1:0]  r_wdog;
  logic [31:0]      r_data;
  logic             r_error;

  logic [DIM_W:0]   w_pad_ext;
  logic [DIM_W:0]   w_span_h;
  logic [DIM_W:0]   w_span_w;
  logic             w_stride2;
  logic [DIM_W:0]   w_oh;
  logic [DIM_W:0]   w_ow;
  logic             w_cfg_ok;
  logic             w_x_end;
  logic             w_y_end;
  logic             w_c_end;
  logic             w_last;

  // Padded extent, then the number of 3-wide window positions at the chosen stride.
  assign w_pad_ext = {{(DIM_W-1){1'b0}}, i_cfg_pad, 1'b0};
  assign w_span_h  = {1'b0, i_cfg_height} + w_pad_ext;
  assign w_span_w  = {1'b0, i_cfg_width} + w_pad_ext;
  assign w_stride2 = (i_cfg_stride == 2'd2);
  assign w_oh      = ((w_span_h - K_THREE) >> w_stride2) + K_ONE;
  assign w_ow      = ((w_span_w - K_THREE) >> w_stride2) + K_ONE;
  assign w_cfg_ok  = ((i_cfg_stride == 2'd1) || w_stride2) && (i_cfg_channels != '0) &&
                     (w_span_h >= K_THREE) && (w_span_w >= K_THREE);

  assign w_x_end = ({1'b0, r_ox} == (r_ow - K_ONE));
  assign w_y_end = ({1'b0, r_oy} == (r_oh - K_ONE));
  assign w_c_end = (r_c == (r_chans - CH_ONE));
  assign w_last  = w_x_end && w_y_end && w_c_end;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_oh      <= '0;
      r_ow      <= '0;
      r_chans   <= '0;
      r_stride2 <= 1'b0;
      r_pad     <= 1'b0;
      r_oy      <= '0;
      r_ox      <= '0;
      r_c       <= '0;
      r_wdog    <= '0;
      r_data    <= '0;
      r_error   <= 1'b0;
    end else begin
      r_error <= 1'b0;
      if (i_abort) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              if (w_cfg_ok) begin
                r_oh      <= w_oh;
                r_ow      <= w_ow;
                r_chans   <= i_cfg_channels;
                r_stride2 <= w_stride2;
                r_pad     <= i_cfg_pad;
                r_oy      <= '0;
                r_ox      <= '0;
                r_c       <= '0;
                r_state   <= S_CLEAR;
              end else begin
                r_error <= 1'b1;
              end
            end
          end
          S_CLEAR: r_state <= S_FETCH;
          S_FETCH: if (i_win_ack) r_state <= S_FIRE;
          S_FIRE: begin
            r_wdog  <= '0;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (i_conv_result_valid) begin
              r_data  <= i_conv_result;
              r_state <= S_EMIT;
            end else if (r_wdog == WD_END) begin
              r_error <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_wdog <= r_wdog + WD_ONE;
            end
          end
          S_EMIT: begin
            if (i_out_ready) begin
              if (w_last) begin
                r_state <= S_DONE;
              end else begin
                r_state <= S_CLEAR;
                if (w_x_end) begin
                  r_ox <= '0;
                  if (w_y_end) begin
                    r_oy <= '0;
                    r_c  <= r_c + CH_ONE;
                  end else begin
                    r_oy <= r_oy + 1'b1;
                  end
                end else begin
                  r_ox <= r_ox + 1'b1;
                end
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Window origin is oy*S - P; oy*S never exceeds 254 so it fits the signed width.
  assign o_win_row    = ({1'b0, r_oy} << r_stride2) - {{DIM_W{1'b0}}, r_pad};
  assign o_win_col    = ({1'b0, r_ox} << r_stride2) - {{DIM_W{1'b0}}, r_pad};
  assign o_win_chan   = r_c;

  assign o_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done       = (r_state == S_DONE);
  assign o_error      = r_error;
  assign o_win_req    = (r_state == S_FETCH);
  assign o_conv_clear = (r_state == S_CLEAR);
  assign o_conv_start = (r_state == S_FIRE);
  assign o_out_valid  = (r_state == S_EMIT);
  assign o_out_data   = r_data;
  assign o_out_row    = r_oy;
  assign o_out_col    = r_ox;
  assign o_out_chan   = r_c;
  assign o_out_last   = (r_state == S_EMIT) && w_last;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_dwconv_tile_scheduler.sv
// Randomised bench for dwconv_tile_scheduler: fetcher/engine/sink models plus a
// reference enumeration of windows and outputs feeding expected queues.
module tb_dwconv_tile_scheduler;
  localparam int DIM_W = 8;
  localparam int CH_W  = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DIM_W-1:0] cfg_height, cfg_width;
  logic [CH_W-1:0]  cfg_channels;
  logic [1:0]       cfg_stride;
  logic             cfg_pad, start, abort;
  logic             busy, done, error, win_req, win_ack;
  logic [DIM_W:0]   win_row, win_col;
  logic [CH_W-1:0]  win_chan;
  logic             conv_clear, conv_start, conv_result_valid;
  logic [31:0]      conv_result;
  logic             out_valid, out_ready, out_last;
  logic [31:0]      out_data;
  logic [DIM_W-1:0] out_row, out_col;
  logic [CH_W-1:0]  out_chan;
  logic [2:0]       dbg_state;

  dwconv_tile_scheduler #(.DIM_W(DIM_W), .CH_W(CH_W), .TIMEOUT(64)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_cfg_height(cfg_height), .i_cfg_width(cfg_width), .i_cfg_channels(cfg_channels),
    .i_cfg_stride(cfg_stride), .i_cfg_pad(cfg_pad), .i_start(start), .i_abort(abort),
    .o_busy(busy), .o_done(done), .o_error(error),
    .o_win_req(win_req), .i_win_ack(win_ack), .o_win_row(win_row), .o_win_col(win_col),
    .o_win_chan(win_chan), .o_conv_clear(conv_clear), .o_conv_start(conv_start),
    .i_conv_result(conv_result), .i_conv_result_valid(conv_result_valid),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_out_row(out_row), .o_out_col(out_col), .o_out_chan(out_chan), .o_out_last(out_last),
    .o_dbg_state(dbg_state)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [58:0] exp_q[$];   // {data, row, col, chan, last}
  logic [27:0] win_q[$];   // {win_row, win_col, win_chan}
  logic [31:0] res_q[$];   // engine results in firing order

  int  ack_fixed = 0, ack_max = 0, stall_max = 0, lat_max = 1;
  int  stall_idx = -1, stall_len = 0, stall_left = 0;
  bit  fresh = 1'b1, eng_en = 1'b1, hold_ready = 1'b0;
  int  n_clear = 0, n_start = 0, n_out = 0, done_cnt = 0, err_cnt = 0;
  int  last_xfer_cyc = 0, start_seen_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Window fetcher model
  initial begin
    win_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (win_req && !rst) begin
        logic [27:0] w;
        int d;
        w = '0;
        check("win_expected", 64'(win_q.size() != 0), 64'd1);
        if (win_q.size() != 0) w = win_q.pop_front();
        d = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, ack_max));
        check("win_coords", {win_row, win_col, win_chan}, w);
        repeat (d) begin
          @(negedge clk);
          check("win_stable", {win_row, win_col, win_chan, win_req}, {w, 1'b1});
        end
        win_ack = 1'b1;
        @(negedge clk);
        win_ack = 1'b0;
      end
    end
  end

  // Engine model: answers each start after a random latency
  initial begin
    conv_result_valid = 1'b0;
    conv_result = '0;
    forever begin
      @(negedge clk);
      if (conv_clear) n_clear++;
      if (conv_start) begin
        n_start++;
        start_seen_cyc = cyc;
        check("clear_before_start", 64'(n_clear), 64'(n_start));
        if (eng_en) begin
          int l;
          l = int'($urandom_range(1, lat_max));
          repeat (l) @(negedge clk);
          conv_result = (res_q.size() != 0) ? res_q.pop_front() : 32'hdeadbeef;
          conv_result_valid = 1'b1;
          @(negedge clk);
          conv_result_valid = 1'b0;
          conv_result = $urandom;
        end
      end
    end
  end

  // Output sink and scoreboard
  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (error) err_cnt++;
      if (out_valid && !rst) begin
        logic [58:0] e;
        e = (exp_q.size() != 0) ? exp_q[0] : '0;
        check("out_expected", 64'(exp_q.size() != 0), 64'd1);
        check("out_fields", {out_data, out_row, out_col, out_chan, out_last}, e);
        if (fresh) begin
          stall_left = (n_out == stall_idx) ? stall_len : int'($urandom_range(0, stall_max));
          fresh = 1'b0;
        end
        if (hold_ready) out_ready = 1'b0;
        else if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          n_out++;
          fresh = 1'b1;
          if (e[0]) last_xfer_cyc = cyc;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
  end

  function automatic bit cfg_legal(input int h, input int w, input int c, input int s, input int p);
    return (s == 1 || s == 2) && c != 0 && (h + 2*p) >= 3 && (w + 2*p) >= 3;
  endfunction

  task automatic launch(input int h, input int w, input int c, input int s, input int p,
                        input bit ab);
    @(negedge clk);
    cfg_height = DIM_W'(h); cfg_width = DIM_W'(w); cfg_channels = CH_W'(c);
    cfg_stride = 2'(s); cfg_pad = p[0]; start = 1'b1; abort = ab;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  // Reference: enumerate window origins stepping by S over the padded map.
  task automatic build_expect(input int h, input int w, input int c, input int s, input int p,
                              output int pixels);
    int nr, nc, iy, ix;
    nr = 0; nc = 0;
    for (int r = -p; r + 3 <= h + p; r += s) nr++;
    for (int q = -p; q + 3 <= w + p; q += s) nc++;
    pixels = c * nr * nc;
    for (int ch = 0; ch < c; ch++) begin
      iy = 0;
      for (int r = -p; r + 3 <= h + p; r += s) begin
        ix = 0;
        for (int q = -p; q + 3 <= w + p; q += s) begin
          logic [31:0] res;
          bit last;
          res = $urandom;
          last = (ch == c - 1) && (iy == nr - 1) && (ix == nc - 1);
          win_q.push_back({9'(r), 9'(q), 10'(ch)});
          res_q.push_back(res);
          exp_q.push_back({res, 8'(iy), 8'(ix), 10'(ch), last});
          ix++;
        end
        iy++;
      end
    end
  endtask

  task automatic flush();
    exp_q.delete(); win_q.delete(); res_q.delete();
    fresh = 1'b1; stall_left = 0;
  endtask

  task automatic run_tile(input int h, input int w, input int c, input int s, input int p);
    int pixels, budget, c0, s0, o0;
    build_expect(h, w, c, s, p, pixels);
    c0 = n_clear; s0 = n_start; o0 = n_out;
    launch(h, w, c, s, p, 1'b0);
    check("busy_after_start", 64'(busy), 64'd1);
    budget = pixels * 40 + 200;
    while (!done && !error && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("tile_done", 64'(done), 64'd1);
    check("tile_no_error", 64'(error), 64'd0);
    check("busy_at_done", 64'(busy), 64'd0);
    check("done_after_last", 64'(cyc), 64'(last_xfer_cyc + 1));
    check("outputs", 64'(n_out - o0), 64'(pixels));
    check("clears", 64'(n_clear - c0), 64'(pixels));
    check("starts", 64'(n_start - s0), 64'(pixels));
    check("queues_drained", 64'(exp_q.size() + win_q.size() + res_q.size()), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_after_done", 64'(dbg_state), 64'd0);
    if (budget <= 0) begin
      rst = 1'b1; @(negedge clk); rst = 1'b0;
    end
    flush();
  endtask

  task automatic bad_cfg(input int h, input int w, input int c, input int s, input int p);
    int e0;
    e0 = err_cnt;
    launch(h, w, c, s, p, 1'b0);
    check("bad_cfg_error", 64'(error), 64'(!cfg_legal(h, w, c, s, p)));
    check("bad_cfg_busy", 64'(busy), 64'd0);
    check("bad_cfg_idle", 64'(dbg_state), 64'd0);
    @(negedge clk);
    check("bad_cfg_pulse", 64'(error), 64'd0);
    check("bad_cfg_count", 64'(err_cnt - e0), 64'd1);
  endtask

  initial begin
    int pix, budget, d0, e0;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_height = '0; cfg_width = '0; cfg_channels = '0; cfg_stride = '0; cfg_pad = 1'b0;
    @(negedge clk);
    check("reset_outputs", {busy, done, error, win_req, conv_clear, conv_start, out_valid,
                            out_last, dbg_state}, 64'd0);
    check("reset_data", {out_data, out_row, out_col, out_chan, win_row, win_col}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed tiles: instant ack/ready, then stride 2 over two channels
    ack_fixed = 0; stall_max = 0; lat_max = 1;
    run_tile(4, 4, 1, 1, 1);
    run_tile(5, 5, 2, 2, 0);

    // Third output held 5 cycles, every ack delayed 3
    ack_fixed = 3; stall_idx = n_out + 2; stall_len = 5; lat_max = 3;
    run_tile(4, 4, 1, 1, 1);
    stall_idx = -1;

    // Random configurations with random handshake timing
    ack_fixed = -1; ack_max = 3; stall_max = 2; lat_max = 4;
    for (int t = 0; t < 8; t++) begin
      int h, w, c, s, p;
      h = int'($urandom_range(2, 7)); w = int'($urandom_range(2, 7));
      s = int'($urandom_range(1, 2)); c = int'($urandom_range(1, 3));
      p = int'($urandom_range(0, 1));
      if (h < 3 || w < 3) p = 1;
      run_tile(h, w, c, s, p);
    end

    // Illegal configurations
    bad_cfg(4, 4, 1, 3, 1);
    bad_cfg(4, 4, 1, 0, 0);
    bad_cfg(4, 4, 0, 1, 0);
    bad_cfg(2, 5, 1, 1, 0);
    bad_cfg(5, 0, 1, 2, 1);

    // Engine never answers: watchdog error after 64 WAIT cycles
    eng_en = 1'b0; d0 = done_cnt;
    build_expect(3, 3, 1, 1, 0, pix);
    launch(3, 3, 1, 1, 0, 1'b0);
    budget = 300;
    while (!error && budget > 0) begin @(negedge clk); budget--; end
    check("timeout_error", 64'(error), 64'd1);
    check("timeout_latency", 64'(cyc), 64'(start_seen_cyc + 65));
    check("timeout_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("timeout_no_done", 64'(done_cnt - d0), 64'd0);
    check("timeout_pulse", 64'(error), 64'd0);
    flush();

    // Abort during WAIT
    d0 = done_cnt; e0 = err_cnt;
    build_expect(3, 3, 1, 1, 0, pix);
    launch(3, 3, 1, 1, 0, 1'b0);
    budget = 100;
    while (!conv_start && budget > 0) begin @(negedge clk); budget--; end
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", {busy, win_req, conv_clear, conv_start, out_valid, dbg_state}, 64'd0);
    repeat (80) @(negedge clk);
    check("abort_no_done_err", 64'((done_cnt - d0) + (err_cnt - e0)), 64'd0);
    flush();
    eng_en = 1'b1;

    // Abort wins over a same-cycle start
    launch(4, 4, 1, 1, 1, 1'b1);
    check("abort_beats_start", {busy, error, dbg_state}, 64'd0);

    // Reset while an output is waiting for ready
    hold_ready = 1'b1;
    build_expect(3, 3, 1, 1, 0, pix);
    launch(3, 3, 1, 1, 0, 1'b0);
    budget = 100;
    while (!out_valid && budget > 0) begin @(negedge clk); budget--; end
    check("reached_emit", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1 check("reset_mid_emit", {out_valid, busy, out_data, dbg_state}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    hold_ready = 1'b0;
    flush();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
